// File: rtl/subbytes_scheduler.sv
// Shares one 32-bit S-box unit between the 128-bit SubBytes round-state operation
// (four column passes) and the key-schedule SubWord operation (one pass).
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   s_valid/s_ready       128-bit state request handshake; s_data column 0 = [127:96]
//   m_valid/m_ready       substituted state handshake; m_data = SubBytes(s_data)
//   k_valid/k_ready       key word request; k_ready is the grant for this cycle
//   k_word                word to run through SubWord
//   k_out_valid, k_out    one-cycle pulse with the registered SubWord result
//   sbox_in, sbox_out     link to the external combinational S-box unit
//   busy                  high while a state operation is in flight or awaiting hand-off
module subbytes_scheduler #(
    parameter bit KEY_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    input  logic         k_valid,
    output logic         k_ready,
    input  logic [31:0]  k_word,
    output logic         k_out_valid,
    output logic [31:0]  k_out,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic              prio_q, prio_d;  // 1: key wins the next contended cycle
    logic [3:0][31:0]  st_q, st_d;
    logic [3:0][31:0]  res_q, res_d;
    logic [31:0]       k_out_q, k_out_d;
    logic              k_out_valid_q, k_out_valid_d;
    logic              grant_k, grant_s;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        prio_d        = prio_q;
        st_d          = st_q;
        res_d         = res_q;
        k_out_d       = k_out_q;
        s_ready       = 1'b0;
        m_valid       = 1'b0;
        sbox_in       = '0;

        // Outside BUSY the key path has the unit to itself.
        grant_k       = k_valid && ((state_q != StBusy) || prio_q);
        grant_s       = (state_q == StBusy) && !grant_k;
        k_out_valid_d = grant_k;

        // Column c sits in packed word 3-c, i.e. ~c for a 2-bit index.
        if (grant_k) begin
            sbox_in = k_word;
            k_out_d = sbox_out;
        end else if (grant_s) begin
            sbox_in = st_q[~col_q];
        end

        // Contended cycle: pointer moves to whoever lost.
        if (state_q == StBusy && k_valid) begin
            prio_d = ~grant_k;
        end

        unique case (state_q)
            StIdle: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    st_d    = s_data;
                    col_d   = 2'd0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (grant_s) begin
                    res_d[~col_q] = sbox_out;
                    col_d         = col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            col_q         <= 2'd0;
            prio_q        <= KEY_FIRST;
            st_q          <= '0;
            res_q         <= '0;
            k_out_q       <= '0;
            k_out_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            prio_q        <= prio_d;
            st_q          <= st_d;
            res_q         <= res_d;
            k_out_q       <= k_out_d;
            k_out_valid_q <= k_out_valid_d;
        end
    end

    assign k_ready     = grant_k;
    assign m_data      = res_q;
    assign k_out       = k_out_q;
    assign k_out_valid = k_out_valid_q;
    assign busy        = (state_q != StIdle);

endmodule
